// File: rtl/ctl_pwm_fade.sv
// Duty-cycle ramp controller: walks o_val one LSB per step toward a requested target,
// updating only at PWM frame boundaries. Optional macro: CTL_PWM_FADE_RETARGET_EN.
module ctl_pwm_fade #(
    parameter int unsigned p_depth  = 10,
    parameter int unsigned p_step_w = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [p_depth-1:0]  i_tgt,
    input  logic [p_step_w-1:0] i_period,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    output logic [p_depth-1:0]  o_val,
    output logic                o_busy,
    output logic                o_done
);

    typedef enum logic {StIdle, StRamp} state_e;

    state_e                state_q, state_d;
    logic [p_depth-1:0]    val_q, val_d;
    logic [p_depth-1:0]    frame_q, frame_d;
    logic [p_depth-1:0]    tgt_q, tgt_d;
    logic [p_step_w-1:0]   per_q, per_d;
    logic [p_step_w-1:0]   div_q, div_d;
    logic                  done_q, done_d;
    logic                  boundary;
    logic                  accept;
    logic [p_depth-1:0]    val_step;

`ifdef CTL_PWM_FADE_RETARGET_EN
    assign o_req_ready = 1'b1;
`else
    assign o_req_ready = (state_q == StIdle);
`endif
    assign o_busy   = (state_q == StRamp);
    assign o_val    = val_q;
    assign o_done   = done_q;
    assign accept   = i_req_valid && o_req_ready;
    assign boundary = (frame_q == {p_depth{1'b1}});
    // Stepping strictly toward the target means this never wraps.
    assign val_step = (tgt_q > val_q) ? val_q + p_depth'(1) : val_q - p_depth'(1);

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        frame_d = frame_q + p_depth'(1);
        tgt_d   = tgt_q;
        per_d   = per_q;
        div_d   = div_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tgt_d = i_tgt;
                    per_d = i_period;
                    div_d = '0;
                    if (i_tgt != val_q) state_d = StRamp;
                    else                done_d  = 1'b1;
                end
            end
            StRamp: begin
                // A retarget accept (only possible with the macro) overrides the boundary update.
                if (accept) begin
                    tgt_d = i_tgt;
                    per_d = i_period;
                    div_d = '0;
                    if (i_tgt == val_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else if (boundary) begin
                    if (div_q == per_q) begin
                        div_d = '0;
                        val_d = val_step;
                        if (val_step == tgt_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d = div_q + p_step_w'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            val_q   <= '0;
            frame_q <= '0;
            tgt_q   <= '0;
            per_q   <= '0;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            frame_q <= frame_d;
            tgt_q   <= tgt_d;
            per_q   <= per_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ctl_pwm_fade.sv
// Scoreboard bench for ctl_pwm_fade: stimulus queues expected output events, a negedge
// monitor pops and compares them whenever o_val changes or o_done pulses.
module tb_ctl_pwm_fade;

    localparam int unsigned Depth = 4;
    localparam int unsigned StepW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [Depth-1:0] tgt = '0;
    logic [StepW-1:0] period = '0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [Depth-1:0] val;
    logic             busy;
    logic             done;

    ctl_pwm_fade #(.p_depth(Depth), .p_step_w(StepW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tgt       (tgt),
        .i_period    (period),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .o_val       (val),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit done;
        bit busy;
        int gap;  // clocks since previous event, -1 = not checked
    } ev_t;

    ev_t q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;
    int  last_cyc = 0;
    int  last_val = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int v, input bit d, input bit b, input int g);
        ev_t e;
        e.val = v; e.done = d; e.busy = b; e.gap = g;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (mon_en && (int'(val) != last_val || done)) begin
            if (q.size() == 0) begin
                chk("unexpected_event_val", int'(val), last_val);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_val", int'(val), e.val);
                chk("ev_done", int'(done), int'(e.done));
                chk("ev_busy", int'(busy), int'(e.busy));
                if (e.gap >= 0) chk("ev_gap", cyc - last_cyc, e.gap);
            end
            last_cyc = cyc;
            last_val = int'(val);
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic request(input int t, input int p);
        @(negedge clk);
        chk("req_ready_before_accept", int'(req_ready), 1);
        tgt = Depth'(t);
        period = StepW'(p);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && q.size() == 0) break;
        end
        if (i == budget) chk("wait_idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_val(input int v, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (int'(val) == v) break;
        end
        if (i == budget) chk("wait_val_timeout", int'(val), v);
    endtask

    initial begin
        // 1: reset values
        do_reset(2);
        chk("rst_val", int'(val), 0);
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        last_val = 0;
        last_cyc = cyc;
        mon_en = 1'b1;

        // 2: ramp up 0 -> 3, one step per frame
        push(1, 0, 1, -1);
        push(2, 0, 1, 16);
        push(3, 1, 0, 16);
        request(3, 0);
        chk("ramp_up_busy", int'(busy), 1);
        chk("ramp_up_ready", int'(req_ready), 0);
        wait_idle(200);

        // 3: ramp down 3 -> 1, one step per three frames
        push(2, 0, 1, -1);
        push(1, 1, 0, 48);
        request(1, 2);
        wait_idle(400);

        // 4: equal target at 5
        push(2, 0, 1, -1);
        push(3, 0, 1, 16);
        push(4, 0, 1, 16);
        push(5, 1, 0, 16);
        request(5, 0);
        wait_idle(300);
        push(5, 1, 0, -1);
        @(negedge clk);
        tgt = Depth'(5);
        period = '0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("eq_done_hi", int'(done), 1);
        chk("eq_busy", int'(busy), 0);
        @(negedge clk);
        chk("eq_done_lo", int'(done), 0);
        chk("eq_busy_after", int'(busy), 0);
        chk("eq_val", int'(val), 5);

        // 5: request presented mid-ramp 0 -> 10
        push(0, 0, 0, -1);
        do_reset(1);
        push(1, 0, 1, -1);
        push(2, 0, 1, 16);
        push(3, 0, 1, 16);
        push(4, 0, 1, 16);
        request(10, 0);
        wait_val(4, 200);
`ifdef CTL_PWM_FADE_RETARGET_EN
        push(3, 0, 1, 16);
        push(2, 1, 0, 16);
        chk("retarget_ready", int'(req_ready), 1);
        tgt = Depth'(2);
        period = '0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle(200);
        chk("retarget_final_val", int'(val), 2);
`else
        for (int k = 5; k <= 10; k++) push(k, k == 10, k != 10, 16);
        tgt = Depth'(2);
        period = '0;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("midramp_ready", int'(req_ready), 0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_idle(300);
        chk("midramp_final_val", int'(val), 10);
`endif

        // 6: reset mid-ramp 0 -> 12 at 6
        push(0, 0, 0, -1);
        do_reset(1);
        for (int k = 1; k <= 6; k++) push(k, 0, 1, (k == 1) ? -1 : 16);
        request(12, 0);
        wait_val(6, 300);
        push(0, 0, 0, -1);
        do_reset(1);
        chk("rst_mid_val", int'(val), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(req_ready), 1);
        begin
            int seen_done;
            seen_done = 0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) seen_done = 1;
            end
            chk("rst_mid_no_done", seen_done, 0);
        end
        chk("rst_mid_val_hold", int'(val), 0);
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ctl_pwm_fade.md
# ctl_pwm_fade

Duty-cycle ramp controller for the `drv_pwm` output driver. It accepts a target duty and a ramp rate over a valid/ready handshake. It then moves its duty output one LSB at a time toward the target, changing the value only at PWM frame boundaries so the driver never sees a mid-frame duty change. `o_val` connects directly to the driver's `i_val`; both blocks share `i_clk` and `i_rst`.

## Interface
- `p_depth`, default 10: duty/frame counter width; must equal the driver's `p_depth`.
- `p_step_w`, default 16: width of the ramp-rate field.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_tgt`  in  `p_depth`  target duty value.
- `i_period`  in  `p_step_w`  a duty step occurs every `i_period+1` frames.
- `i_req_valid`  in  1  request valid.
- `o_req_ready`  out  1  request accepted when high together with `i_req_valid`.
- `o_val`  out  `p_depth`  current duty value, to the driver's `i_val`.
- `o_busy`  out  1  high while in RAMP.
- `o_done`  out  1  one-cycle pulse when `o_val` reaches the accepted target.

## Operation
- **Frame counter `l_frame`:**
  - Width `p_depth`, reset 0, increments every clock and wraps.
  - The boundary cycle is `l_frame == 2^p_depth-1`. An `o_val` update at that edge is applied from driver count 0 onward.
  - Lockstep with the driver is guaranteed by the shared reset.
- **Latched fields:** `l_tgt`, `l_per`, and the frame divider `l_div` (`p_step_w` bits).
- **FSM states:** IDLE, RAMP.
- **IDLE:**
  - `o_req_ready=1`, `o_busy=0`.
  - On accept, latch `i_tgt` and `i_period`, and clear `l_div`.
  - If `i_tgt != o_val`, go to RAMP.
  - If `i_tgt == o_val`, stay in IDLE and pulse `o_done` in the next cycle. `o_val` is unchanged.
- **RAMP:**
  - `o_busy=1`. `o_req_ready=0`, unless the configuration macro below is defined.
  - At each boundary cycle: if `l_div == l_per`, clear `l_div` and step `o_val` by +1 or −1 toward `l_tgt`. Otherwise increment `l_div`.
  - If the step makes `o_val == l_tgt`, go to IDLE and pulse `o_done` in the first cycle where `o_val` shows the target.
- **Arithmetic:**
  - `o_val` steps only toward `l_tgt`, so it never wraps.
  - `l_div` compares for equality only; `l_per = 2^p_step_w-1` is legal.
- **Inputs while not ready:** `i_req_valid` while `o_req_ready=0` is held off by the requester; the block ignores the inputs.
- **Reset (any state, including mid-ramp):** takes effect at the next clock edge.
  - `o_val=0`, `l_frame=0`, `l_div=0`, state IDLE.
  - `o_req_ready=1`, `o_busy=0`, `o_done=0`.

## Timing
- **Output timing:** `o_req_ready` and `o_busy` are decoded from the state. `o_done` and `o_val` are registered.
- **Boundary counting:**
  - An accept taking place in a boundary cycle does not count that boundary.
  - The first step happens at the `(l_per+1)`-th boundary after acceptance.
- **Ramp duration:**
  - Step interval: `(l_per+1)·2^p_depth` clocks.
  - Total ramp: `|tgt−val0|·(l_per+1)` boundaries.
- **`o_done`:**
  - Exactly 1 cycle.
  - Coincides with the first cycle of IDLE after a ramp, in which `o_req_ready=1`.
  - A new request accepted in that cycle is valid.
- **Equal-target request:** accept edge, then `o_done` high for one cycle, then low.

## Configuration
- **`CTL_PWM_FADE_RETARGET_EN` defined:**
  - `o_req_ready=1` in RAMP as well.
  - An accept in RAMP replaces `l_tgt` and `l_per`, clears `l_div`, and leaves `o_val` unchanged.
  - If the new target equals `o_val`, go to IDLE and pulse `o_done`.
  - An accept in a boundary cycle overrides that cycle's step/divider update.
- **Not defined:** `o_req_ready=0` throughout RAMP; a ramp always runs to completion or to reset.

## Test plan
1. **Reset values:** assert `i_rst` for 2 cycles → `o_val=0`, `o_req_ready=1`, `o_busy=0`, `o_done=0`.
2. **Ramp up:** `p_depth=4`, from `o_val=0`, request tgt=3, period=0.
   - `o_val` becomes 1, 2, 3 on successive boundary edges, 16 clocks apart.
   - `o_done` pulses once, in the cycle `o_val` first reads 3; `o_busy` falls in that same cycle.
3. **Ramp down:** from 3, request tgt=1, period=2.
   - `o_val` becomes 2 at the 3rd boundary after accept and 1 at the 6th (48 clocks apart).
   - Done pulses at 1.
4. **Equal target:** with `o_val=5`, request tgt=5 → `o_done` high for one cycle after the accept, `o_busy` never high, `o_val` stays 5.
5. **Request mid-ramp:** during a 0→10 ramp (period=0), present tgt=2 at `o_val=4`.
   - Without the macro: ready stays low and the ramp reaches 10.
   - With `CTL_PWM_FADE_RETARGET_EN`: accepted, and `o_val` goes 3, 2, then done.
6. **Reset mid-ramp:** at `o_val=6` of a ramp to 12, assert `i_rst` for 1 cycle → `o_val=0`, IDLE, and no `o_done` pulse afterward.
